// File: rtl/mac_pkg.sv
// -----------------------------------------------------------------------------
// mac_pkg
// Shared definitions for the MAC accumulate pipeline: default widths and the
// saturation-bound helpers used by the accumulate stage.
// No ports (package).
// -----------------------------------------------------------------------------
package mac_pkg;

    localparam int MAC_IN_W  = 8;
    localparam int MAC_ACC_W = 24;
    localparam int MAC_CNT_W = 10;

    // Largest value an acc_w-bit accumulator can hold, returned in 64 bits;
    // the caller truncates to acc_w. Valid for acc_w up to 63.
    function automatic logic [63:0] sat_max(input int acc_w, input logic is_signed);
        logic [63:0] one_v;
        one_v = 64'd1;
        if (is_signed) begin
            return (one_v << (acc_w - 1)) - 64'd1;
        end else begin
            return (one_v << acc_w) - 64'd1;
        end
    endfunction

    // Smallest value an acc_w-bit accumulator can hold (two's complement when
    // signed), returned in 64 bits; the caller truncates to acc_w.
    function automatic logic [63:0] sat_min(input int acc_w, input logic is_signed);
        logic [63:0] one_v;
        one_v = 64'd1;
        if (is_signed) begin
            return ~((one_v << (acc_w - 1)) - 64'd1);
        end else begin
            return 64'd0;
        end
    endfunction

endpackage

// File: rtl/mac_mult_stage.sv
// -----------------------------------------------------------------------------
// mac_mult_stage
// Operand register (S1) followed by the registered multiplier (S2).
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   en                pipeline advance; both stages hold when low
//   in_fire           a beat is accepted this cycle
//   a, b, in_last     operand beat
//   prod              registered product, 2*IN_W bits
//   v2, last2         product valid / product belongs to the last beat
// -----------------------------------------------------------------------------
module mac_mult_stage
    import mac_pkg::*;
#(
    parameter int IN_W   = MAC_IN_W,
    parameter int SIGNED = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              in_fire,
    input  logic [IN_W-1:0]   a,
    input  logic [IN_W-1:0]   b,
    input  logic              in_last,
    output logic [2*IN_W-1:0] prod,
    output logic              v2,
    output logic              last2
);

    logic [IN_W-1:0]   a_r;
    logic [IN_W-1:0]   b_r;
    logic              v1_r;
    logic              last1_r;
    logic [2*IN_W-1:0] prod_r;
    logic              v2_r;
    logic              last2_r;
    logic [2*IN_W-1:0] a_ext_s;
    logic [2*IN_W-1:0] b_ext_s;
    logic [2*IN_W-1:0] prod_s;

    // Widen operands to product width; the low 2*IN_W bits of the product of
    // the extended values equal the exact signed or unsigned product.
    always_comb begin
        a_ext_s = {{IN_W{1'b0}}, a_r};
        b_ext_s = {{IN_W{1'b0}}, b_r};
        if (SIGNED != 0) begin
            a_ext_s = {{IN_W{a_r[IN_W-1]}}, a_r};
            b_ext_s = {{IN_W{b_r[IN_W-1]}}, b_r};
        end else begin
            a_ext_s = {{IN_W{1'b0}}, a_r};
            b_ext_s = {{IN_W{1'b0}}, b_r};
        end
        prod_s = a_ext_s * b_ext_s;
    end

    // S1 operand capture and S2 product register, frozen together with en.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_r     <= {IN_W{1'b0}};
            b_r     <= {IN_W{1'b0}};
            v1_r    <= 1'b0;
            last1_r <= 1'b0;
            prod_r  <= {(2*IN_W){1'b0}};
            v2_r    <= 1'b0;
            last2_r <= 1'b0;
        end else if (en) begin
            a_r     <= a;
            b_r     <= b;
            v1_r    <= in_fire;
            // in_last without an accepted beat must not close a vector
            last1_r <= in_last & in_fire;
            prod_r  <= prod_s;
            v2_r    <= v1_r;
            last2_r <= last1_r;
        end else begin
            a_r     <= a_r;
            b_r     <= b_r;
            v1_r    <= v1_r;
            last1_r <= last1_r;
            prod_r  <= prod_r;
            v2_r    <= v2_r;
            last2_r <= last2_r;
        end
    end

    assign prod  = prod_r;
    assign v2    = v2_r;
    assign last2 = last2_r;

endmodule

// File: rtl/mac_accum_pipeline.sv
// -----------------------------------------------------------------------------
// mac_accum_pipeline
// 3-stage pipelined multiply-accumulate engine. Accumulates a*b over a vector
// terminated by in_last and emits one dot product per vector with its beat
// count and a sticky overflow flag.
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   in_valid/in_ready           operand beat handshake
//   a, b, in_last               operands and end-of-vector marker
//   out_valid/out_ready         result handshake (result held until taken)
//   out_data, out_len, out_ovf  dot product, beat count, overflow seen
// -----------------------------------------------------------------------------
module mac_accum_pipeline
    import mac_pkg::*;
#(
    parameter int IN_W   = MAC_IN_W,
    parameter int ACC_W  = MAC_ACC_W,
    parameter int SIGNED = 1,
    parameter int SAT    = 1,
    parameter int CNT_W  = MAC_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  a,
    input  logic [IN_W-1:0]  b,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_data,
    output logic [CNT_W-1:0] out_len,
    output logic             out_ovf
);

    localparam int PROD_W = 2 * IN_W;
    localparam int EXT_W  = ACC_W + 1 - PROD_W;
    localparam logic [ACC_W-1:0] SAT_MAX_C = ACC_W'(sat_max(ACC_W, SIGNED != 0));
    localparam logic [ACC_W-1:0] SAT_MIN_C = ACC_W'(sat_min(ACC_W, SIGNED != 0));

    if (ACC_W < 2 * IN_W) begin : g_width_check
        $error("mac_accum_pipeline: ACC_W must be >= 2*IN_W");
    end

    logic              en_s;
    logic              fire_s;
    logic [PROD_W-1:0] prod_s;
    logic              v2_s;
    logic              last2_s;
    logic [ACC_W:0]    prod_ext_s;
    logic [ACC_W:0]    acc_ext_s;
    logic [ACC_W:0]    sum_s;
    logic              ovf_s;
    logic [ACC_W-1:0]  result_s;

    logic [ACC_W-1:0]  acc_r;
    logic [CNT_W-1:0]  cnt_r;
    logic              sticky_r;
    logic              out_valid_r;
    logic [ACC_W-1:0]  out_data_r;
    logic [CNT_W-1:0]  out_len_r;
    logic              out_ovf_r;

    // A held, untaken result stalls every stage including the input.
    assign en_s     = ~(out_valid_r & ~out_ready);
    assign in_ready = en_s;
    assign fire_s   = in_valid & en_s;

    mac_mult_stage #(
        .IN_W   (IN_W),
        .SIGNED (SIGNED)
    ) u_mult (
        .clk     (clk),
        .rst     (rst),
        .en      (en_s),
        .in_fire (fire_s),
        .a       (a),
        .b       (b),
        .in_last (in_last),
        .prod    (prod_s),
        .v2      (v2_s),
        .last2   (last2_s)
    );

    // S3 datapath: one guard bit above ACC_W exposes overflow; saturate or wrap.
    always_comb begin
        prod_ext_s = {{EXT_W{1'b0}}, prod_s};
        acc_ext_s  = {1'b0, acc_r};
        if (SIGNED != 0) begin
            prod_ext_s = {{EXT_W{prod_s[PROD_W-1]}}, prod_s};
            acc_ext_s  = {acc_r[ACC_W-1], acc_r};
        end else begin
            prod_ext_s = {{EXT_W{1'b0}}, prod_s};
            acc_ext_s  = {1'b0, acc_r};
        end
        sum_s = acc_ext_s + prod_ext_s;
        if (SIGNED != 0) begin
            ovf_s = sum_s[ACC_W] ^ sum_s[ACC_W-1];
        end else begin
            ovf_s = sum_s[ACC_W];
        end
        if (ovf_s && (SAT != 0)) begin
            // the guard bit holds the true sign; unsigned overflow is always upward
            if ((SIGNED != 0) && sum_s[ACC_W]) begin
                result_s = SAT_MIN_C;
            end else begin
                result_s = SAT_MAX_C;
            end
        end else begin
            result_s = sum_s[ACC_W-1:0];
        end
    end

    // Accumulator, beat counter, sticky overflow and the result register.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_r       <= {ACC_W{1'b0}};
            cnt_r       <= {CNT_W{1'b0}};
            sticky_r    <= 1'b0;
            out_valid_r <= 1'b0;
            out_data_r  <= {ACC_W{1'b0}};
            out_len_r   <= {CNT_W{1'b0}};
            out_ovf_r   <= 1'b0;
        end else if (en_s) begin
            // en_s implies any held result is being taken this edge
            out_valid_r <= v2_s & last2_s;
            if (v2_s && last2_s) begin
                out_data_r <= result_s;
                out_len_r  <= cnt_r + CNT_W'(1);
                out_ovf_r  <= sticky_r | ovf_s;
                acc_r      <= {ACC_W{1'b0}};
                cnt_r      <= {CNT_W{1'b0}};
                sticky_r   <= 1'b0;
            end else if (v2_s) begin
                acc_r    <= result_s;
                cnt_r    <= cnt_r + CNT_W'(1);
                sticky_r <= sticky_r | ovf_s;
            end else begin
                acc_r    <= acc_r;
                cnt_r    <= cnt_r;
                sticky_r <= sticky_r;
            end
        end else begin
            out_valid_r <= out_valid_r;
            acc_r       <= acc_r;
            cnt_r       <= cnt_r;
            sticky_r    <= sticky_r;
        end
    end

    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign out_len   = out_len_r;
    assign out_ovf   = out_ovf_r;

endmodule

// File: tb/tb_mac_accum_pipeline.sv
// -----------------------------------------------------------------------------
// tb_mac_accum_pipeline
// Four configurations of mac_accum_pipeline share one stimulus stream:
//   0: signed,   ACC_W=24, saturate     1: unsigned, ACC_W=24, saturate
//   2: signed,   ACC_W=16, saturate     3: signed,   ACC_W=16, wrap
// A scoreboard computes each vector's expected result from the accepted beats
// with plain integer arithmetic; directed rows and sequences cover latency,
// saturation, back-to-back vectors, backpressure, bubbles and reset.
// -----------------------------------------------------------------------------
module tb_mac_accum_pipeline;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_last;
    logic       out_ready;
    logic [7:0] a;
    logic [7:0] b;

    logic        rdy_s, rdy_u, rdy_s16, rdy_w16;
    logic        ov_s, ov_u, ov_s16, ov_w16;
    logic [23:0] od_s, od_u;
    logic [15:0] od_s16, od_w16;
    logic [9:0]  ol_s, ol_u, ol_s16, ol_w16;
    logic        oo_s, oo_u, oo_s16, oo_w16;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [3:0][63:0] d;
        logic [3:0]       o;
        int               len;
    } exp_t;

    typedef struct {
        int              nb;
        logic [2:0][7:0] va;
        logic [2:0][7:0] vb;
        bit              gap;
        int              dut;
        longint          data;
        int              len;
        bit              ovf;
    } vec_t;

    logic [7:0] bq_a[$];
    logic [7:0] bq_b[$];
    exp_t       exp_q[$];
    exp_t       sb_e;
    vec_t       tbl[6];

    always #5 clk = ~clk;

    mac_accum_pipeline #(.IN_W(8), .ACC_W(24), .SIGNED(1), .SAT(1), .CNT_W(10)) u_s (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_s), .a(a), .b(b),
        .in_last(in_last), .out_valid(ov_s), .out_ready(out_ready), .out_data(od_s),
        .out_len(ol_s), .out_ovf(oo_s));

    mac_accum_pipeline #(.IN_W(8), .ACC_W(24), .SIGNED(0), .SAT(1), .CNT_W(10)) u_u (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_u), .a(a), .b(b),
        .in_last(in_last), .out_valid(ov_u), .out_ready(out_ready), .out_data(od_u),
        .out_len(ol_u), .out_ovf(oo_u));

    mac_accum_pipeline #(.IN_W(8), .ACC_W(16), .SIGNED(1), .SAT(1), .CNT_W(10)) u_s16 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_s16), .a(a), .b(b),
        .in_last(in_last), .out_valid(ov_s16), .out_ready(out_ready), .out_data(od_s16),
        .out_len(ol_s16), .out_ovf(oo_s16));

    mac_accum_pipeline #(.IN_W(8), .ACC_W(16), .SIGNED(1), .SAT(0), .CNT_W(10)) u_w16 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_w16), .a(a), .b(b),
        .in_last(in_last), .out_valid(ov_w16), .out_ready(out_ready), .out_data(od_w16),
        .out_len(ol_w16), .out_ovf(oo_w16));

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    function automatic longint get_data(input int i);
        case (i)
            0:       return longint'($signed(od_s));
            1:       return longint'(od_u);
            2:       return longint'($signed(od_s16));
            default: return longint'($signed(od_w16));
        endcase
    endfunction

    function automatic int get_len(input int i);
        case (i)
            0:       return int'(ol_s);
            1:       return int'(ol_u);
            2:       return int'(ol_s16);
            default: return int'(ol_w16);
        endcase
    endfunction

    function automatic logic get_ovf(input int i);
        case (i)
            0:       return oo_s;
            1:       return oo_u;
            2:       return oo_s16;
            default: return oo_w16;
        endcase
    endfunction

    function automatic logic get_ov(input int i);
        case (i)
            0:       return ov_s;
            1:       return ov_u;
            2:       return ov_s16;
            default: return ov_w16;
        endcase
    endfunction

    function automatic logic get_rdy(input int i);
        case (i)
            0:       return rdy_s;
            1:       return rdy_u;
            2:       return rdy_s16;
            default: return rdy_w16;
        endcase
    endfunction

    // Reference: dot product of the queued beats under the accumulate rules.
    function automatic void model(input int accw, input bit sgn, input bit sat,
                                  output longint data, output bit ovf);
        longint acc, p, maxv, minv, span;
        span = longint'(1) <<< accw;
        if (sgn) begin
            maxv = span / 2 - 1;
            minv = -(span / 2);
        end else begin
            maxv = span - 1;
            minv = 0;
        end
        acc = 0;
        ovf = 1'b0;
        foreach (bq_a[k]) begin
            if (sgn) p = longint'($signed(bq_a[k])) * longint'($signed(bq_b[k]));
            else     p = longint'(bq_a[k]) * longint'(bq_b[k]);
            acc = acc + p;
            if (acc > maxv || acc < minv) begin
                ovf = 1'b1;
                if (sat) begin
                    acc = (acc > maxv) ? maxv : minv;
                end else begin
                    acc = acc & (span - 1);
                    if (acc > maxv) acc = acc - span;
                end
            end
        end
        data = acc;
    endfunction

    function automatic vec_t mk(input int nb, input logic [7:0] a0, input logic [7:0] b0,
                                input logic [7:0] a1, input logic [7:0] b1,
                                input logic [7:0] a2, input logic [7:0] b2, input bit gap,
                                input int dut, input longint data, input int len, input bit ovf);
        vec_t v;
        v.nb = nb;  v.va = {a2, a1, a0};  v.vb = {b2, b1, b0};  v.gap = gap;
        v.dut = dut;  v.data = data;  v.len = len;  v.ovf = ovf;
        return v;
    endfunction

    // Scoreboard: sampled on the falling edge, mid-cycle.
    always @(negedge clk) begin
        if (rst) begin
            bq_a.delete();
            bq_b.delete();
            exp_q.delete();
        end else begin
            if (ov_s && out_ready) begin
                chk("sb_pending", (exp_q.size() > 0) ? 1 : 0, 1);
                if (exp_q.size() > 0) begin
                    sb_e = exp_q.pop_front();
                    for (int i = 0; i < 4; i++) begin
                        chk($sformatf("sb_valid[%0d]", i), longint'(get_ov(i)), 1);
                        chk($sformatf("sb_data[%0d]", i), get_data(i), $signed(sb_e.d[i]));
                        chk($sformatf("sb_len[%0d]", i), longint'(get_len(i)), longint'(sb_e.len));
                        chk($sformatf("sb_ovf[%0d]", i), longint'(get_ovf(i)), longint'(sb_e.o[i]));
                    end
                end
            end
            if (in_valid && rdy_s) begin
                bq_a.push_back(a);
                bq_b.push_back(b);
                if (in_last) begin
                    longint md;
                    bit     mo;
                    model(24, 1'b1, 1'b1, md, mo);  sb_e.d[0] = md;  sb_e.o[0] = mo;
                    model(24, 1'b0, 1'b1, md, mo);  sb_e.d[1] = md;  sb_e.o[1] = mo;
                    model(16, 1'b1, 1'b1, md, mo);  sb_e.d[2] = md;  sb_e.o[2] = mo;
                    model(16, 1'b1, 1'b0, md, mo);  sb_e.d[3] = md;  sb_e.o[3] = mo;
                    sb_e.len = bq_a.size();
                    exp_q.push_back(sb_e);
                    bq_a.delete();
                    bq_b.delete();
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called right after the edge that accepted a last beat; that edge is 1.
    task automatic wait_out(input int d, output int lat);
        lat = 1;
        while (!get_ov(d) && lat < 12) begin
            step();
            lat++;
        end
    endtask

    initial begin
        int lat;
        rst = 1'b1;  in_valid = 1'b0;  in_last = 1'b0;
        a = 8'd0;  b = 8'd0;  out_ready = 1'b1;

        tbl[0] = mk(3, 8'd3, 8'd4, 8'd5, 8'd6, 8'd2, 8'd10, 1'b0, 1, 62, 3, 1'b0);
        tbl[1] = mk(1, 8'h80, 8'h80, 8'd0, 8'd0, 8'd0, 8'd0, 1'b0, 0, 16384, 1, 1'b0);
        tbl[2] = mk(1, 8'hFE, 8'd3, 8'd0, 8'd0, 8'd0, 8'd0, 1'b0, 0, -6, 1, 1'b0);
        tbl[3] = mk(3, 8'd127, 8'd127, 8'd127, 8'd127, 8'd127, 8'd127, 1'b0, 2, 32767, 3, 1'b1);
        tbl[4] = mk(3, 8'd127, 8'd127, 8'd127, 8'd127, 8'd127, 8'd127, 1'b0, 3, -17149, 3, 1'b1);
        tbl[5] = mk(3, 8'd1, 8'd1, 8'd2, 8'd2, 8'd3, 8'd3, 1'b1, 0, 14, 3, 1'b0);

        step();
        step();
        rst = 1'b0;
        chk("rst_in_ready", longint'(rdy_s), 1);
        chk("rst_out_valid", longint'(ov_s), 0);
        chk("rst_out_data", get_data(0), 0);
        chk("rst_out_len", longint'(get_len(0)), 0);
        chk("rst_out_ovf", longint'(oo_s), 0);

        // Table rows: single vectors with result, length, overflow and latency.
        for (int r = 0; r < 6; r++) begin
            for (int j = 0; j < tbl[r].nb; j++) begin
                in_valid = 1'b1;
                a = tbl[r].va[j];
                b = tbl[r].vb[j];
                in_last = (j == tbl[r].nb - 1);
                step();
                if (tbl[r].gap && j < tbl[r].nb - 1) begin
                    in_valid = 1'b0;
                    in_last = 1'b1;
                    step();
                end
            end
            in_valid = 1'b0;
            in_last = 1'b0;
            wait_out(tbl[r].dut, lat);
            chk($sformatf("row%0d_latency", r), longint'(lat), 3);
            chk($sformatf("row%0d_data", r), get_data(tbl[r].dut), tbl[r].data);
            chk($sformatf("row%0d_len", r), longint'(get_len(tbl[r].dut)), longint'(tbl[r].len));
            chk($sformatf("row%0d_ovf", r), longint'(get_ovf(tbl[r].dut)), longint'(tbl[r].ovf));
            step();
        end

        // Back-to-back single-beat vectors: results on consecutive cycles.
        in_valid = 1'b1;  a = 8'h80;  b = 8'h80;  in_last = 1'b1;
        step();
        a = 8'hFE;  b = 8'd3;
        step();
        in_valid = 1'b0;  in_last = 1'b0;
        step();
        chk("b2b_first_valid", longint'(ov_s), 1);
        chk("b2b_first_data", get_data(0), 16384);
        step();
        chk("b2b_second_valid", longint'(ov_s), 1);
        chk("b2b_second_data", get_data(0), -6);
        chk("b2b_second_len", longint'(get_len(0)), 1);
        step();

        // Backpressure: result held for 5 cycles while beats keep arriving.
        out_ready = 1'b0;
        in_valid = 1'b1;  a = 8'd2;  b = 8'd3;  in_last = 1'b1;
        step();
        a = 8'd1;  b = 8'd1;  in_last = 1'b0;
        step();
        step();
        chk("bp_valid", longint'(ov_s), 1);
        for (int k = 0; k < 5; k++) begin
            chk("bp_in_ready", longint'(get_rdy(k % 4)), 0);
            chk("bp_hold_data", get_data(0), 6);
            chk("bp_hold_len", longint'(get_len(0)), 1);
            step();
        end
        out_ready = 1'b1;
        step();
        in_last = 1'b1;
        step();
        in_valid = 1'b0;  in_last = 1'b0;
        wait_out(0, lat);
        chk("bp_next_latency", longint'(lat), 3);
        chk("bp_next_data", get_data(0), 4);
        chk("bp_next_len", longint'(get_len(0)), 4);
        step();

        // Reset mid-vector: partial sum and in-flight beats are dropped.
        in_valid = 1'b1;  a = 8'd5;  b = 8'd5;  in_last = 1'b0;
        step();
        a = 8'd6;  b = 8'd6;
        step();
        in_valid = 1'b0;  rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_rst_valid", longint'(ov_s), 0);
        chk("mid_rst_data", get_data(0), 0);
        chk("mid_rst_len", longint'(get_len(0)), 0);
        chk("mid_rst_ovf", longint'(oo_s), 0);
        in_valid = 1'b1;  a = 8'd7;  b = 8'd8;  in_last = 1'b1;
        step();
        in_valid = 1'b0;  in_last = 1'b0;
        wait_out(0, lat);
        chk("post_rst_data", get_data(0), 56);
        chk("post_rst_len", longint'(get_len(0)), 1);
        step();

        // Random traffic with random backpressure, checked by the scoreboard.
        for (int c = 0; c < 600; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            a         = 8'($urandom);
            b         = 8'($urandom);
            in_last   = ($urandom_range(0, 3) == 0);
            out_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        in_valid = 1'b1;  in_last = 1'b1;  out_ready = 1'b1;
        step();
        in_valid = 1'b0;  in_last = 1'b0;
        for (int c = 0; c < 10; c++) step();
        chk("drain_pending", longint'(exp_q.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
